// File: rtl/aes_pkg.sv
// Shared AES definitions: block width, round counts, sequencer state encoding and the
// GF(2^8) helpers used by the round datapaths.
package aes_pkg;
  localparam int AES_BLK_W      = 128;
  localparam int NR_AES128      = 10;
  localparam int NR_AES192      = 12;
  localparam int NR_AES256      = 14;
  localparam int KIDX_W_DEFAULT = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    FINAL = 2'd2,
    DONE  = 2'd3
  } state_t;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = '0;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xtime(aa);
    end
    return p;
  endfunction

  // S-box built from the field inverse (a^254, zero maps to zero) and the affine map.
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] sq;
    logic [7:0] inv;
    sq  = a;
    inv = 8'h01;
    for (int i = 0; i < 7; i++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]} ^
           {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  // SubBytes followed by ShiftRows; byte 4*c+r is row r of column c.
  function automatic logic [AES_BLK_W-1:0] sub_shift(input logic [AES_BLK_W-1:0] s);
    logic [AES_BLK_W-1:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127-8*(4*c+r) -: 8] = sbox(s[127-8*(4*((c+r)%4)+r) -: 8]);
      end
    end
    return o;
  endfunction

  function automatic logic [AES_BLK_W-1:0] mix_columns(input logic [AES_BLK_W-1:0] s);
    logic [AES_BLK_W-1:0] o;
    logic [7:0] a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      o[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      o[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      o[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
    return o;
  endfunction
endpackage

// File: rtl/aes_final_round.sv
// Last AES round: SubBytes, ShiftRows, AddRoundKey (MixColumns is skipped).
module aes_final_round
  import aes_pkg::*;
(
  input  logic [AES_BLK_W-1:0] in_state,
  input  logic [AES_BLK_W-1:0] round_key,
  output logic [AES_BLK_W-1:0] out_state
);
  assign out_state = sub_shift(in_state) ^ round_key;
endmodule

// File: rtl/cipher_round.sv
// One full AES middle round: SubBytes, ShiftRows, MixColumns, AddRoundKey.
module cipher_round
  import aes_pkg::*;
(
  input  logic [AES_BLK_W-1:0] in_state,
  input  logic [AES_BLK_W-1:0] round_key,
  output logic [AES_BLK_W-1:0] out_state
);
  assign out_state = mix_columns(sub_shift(in_state)) ^ round_key;
endmodule

// File: rtl/aes_round_sequencer.sv
// Iterative AES encryption controller: one block in flight, middle rounds folded onto a
// single cipher_round, last round on aes_final_round, round keys fetched by index.
module aes_round_sequencer
  import aes_pkg::*;
#(
  parameter int NR     = NR_AES256,
  parameter int KIDX_W = KIDX_W_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [AES_BLK_W-1:0] in_data,
  output logic [KIDX_W-1:0]    key_idx,
  input  logic [AES_BLK_W-1:0] key_in,
  input  logic                 key_valid,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [AES_BLK_W-1:0] out_data
);
  if (!(NR == NR_AES128 || NR == NR_AES192 || NR == NR_AES256)) begin : g_bad_nr
    $error("aes_round_sequencer: NR must be 10, 12 or 14");
  end
  if ((1 << KIDX_W) <= NR) begin : g_bad_kidx
    $error("aes_round_sequencer: KIDX_W too narrow for NR");
  end

  localparam logic [KIDX_W-1:0] LAST_MID = KIDX_W'(NR - 1);

  state_t               state, state_nx;
  logic [KIDX_W-1:0]    rnd, rnd_nx;
  logic [AES_BLK_W-1:0] state_reg, state_reg_nx;
  logic [AES_BLK_W-1:0] out_data_nx;
  logic                 out_valid_nx;
  logic [AES_BLK_W-1:0] round_out, final_out;

  cipher_round u_round (
    .in_state (state_reg),
    .round_key(key_in),
    .out_state(round_out)
  );

  aes_final_round u_final (
    .in_state (state_reg),
    .round_key(key_in),
    .out_state(final_out)
  );

  // A transfer happens on a rising edge where valid and ready are both high; valid, once
  // raised, holds with stable data until that edge. The input side only opens in IDLE.
  assign in_ready = rst_n && (state == IDLE) && key_valid;
  assign key_idx  = rnd;

  always_comb begin
    state_nx     = state;
    rnd_nx       = rnd;
    state_reg_nx = state_reg;
    out_data_nx  = out_data;
    out_valid_nx = out_valid;
    case (state)
      IDLE: begin
        if (in_valid && in_ready) begin
          state_reg_nx = in_data ^ key_in;
          rnd_nx       = KIDX_W'(1);
          state_nx     = ROUND;
        end
      end
      ROUND: begin
        if (key_valid) begin
          state_reg_nx = round_out;
          rnd_nx       = rnd + KIDX_W'(1);
          if (rnd >= LAST_MID) state_nx = FINAL;
        end
      end
      FINAL: begin
        if (key_valid) begin
          out_data_nx  = final_out;
          out_valid_nx = 1'b1;
          rnd_nx       = '0;
          state_nx     = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_nx = 1'b0;
          state_nx     = IDLE;
        end
      end
      default: begin
        state_nx     = IDLE;
        rnd_nx       = '0;
        out_valid_nx = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      rnd       <= '0;
      state_reg <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
    end else begin
      state     <= state_nx;
      rnd       <= rnd_nx;
      state_reg <= state_reg_nx;
      out_data  <= out_data_nx;
      out_valid <= out_valid_nx;
    end
  end
endmodule

// File: tb/tb_aes_round_sequencer.sv
// Directed bench for aes_round_sequencer: an AES-256 instance and an AES-128 instance,
// each fed from a bench-side key store, with a scoreboard queue per instance.
module tb_aes_round_sequencer;
  import aes_pkg::*;

  localparam logic [7:0] SBOX [0:255] = '{
    8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
    8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
    8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
    8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
    8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
    8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
    8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
    8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
    8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
    8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
    8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
    8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
    8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
    8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
    8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
    8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
  };

  localparam logic [255:0] KEY256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [255:0] KEY128A = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
  localparam logic [255:0] KEY128B = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
  localparam logic [127:0] PT   = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT14 = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [127:0] CT10 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] PTB  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CTB  = 128'h3925841d02dc09fbdc118597196a0b32;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT signals ----------------
  logic         in_valid14, in_ready14, key_valid14, out_valid14, out_ready14;
  logic [127:0] in_data14, key_in14, out_data14;
  logic [3:0]   key_idx14;
  logic         in_valid10, in_ready10, key_valid10, out_valid10, out_ready10;
  logic [127:0] in_data10, key_in10, out_data10;
  logic [3:0]   key_idx10;

  logic [127:0] ks14 [0:15];
  logic [127:0] ks10 [0:15];
  logic [31:0]  w    [0:59];
  assign key_in14 = ks14[key_idx14];
  assign key_in10 = ks10[key_idx10];

  aes_round_sequencer #(.NR(14), .KIDX_W(4)) d14 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid14), .in_ready(in_ready14),
    .in_data(in_data14), .key_idx(key_idx14), .key_in(key_in14), .key_valid(key_valid14),
    .out_valid(out_valid14), .out_ready(out_ready14), .out_data(out_data14)
  );

  aes_round_sequencer #(.NR(10), .KIDX_W(4)) d10 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid10), .in_ready(in_ready10),
    .in_data(in_data10), .key_idx(key_idx10), .key_in(key_in10), .key_valid(key_valid10),
    .out_valid(out_valid10), .out_ready(out_ready10), .out_data(out_data10)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [127:0] exp_q14[$];
  logic [127:0] exp_q10[$];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && out_valid14 && out_ready14) begin
      if (exp_q14.size() == 0) chk("out14_unexpected", 128'(out_valid14), 128'(0));
      else chk("out14_data", out_data14, exp_q14.pop_front());
    end
    if (rst_n && out_valid10 && out_ready10) begin
      if (exp_q10.size() == 0) chk("out10_unexpected", 128'(out_valid10), 128'(0));
      else chk("out10_data", out_data10, exp_q10.pop_front());
    end
  end

  // ---------------- key schedule ----------------
  function automatic logic [31:0] sub_word(input logic [31:0] x);
    return {SBOX[x[31:24]], SBOX[x[23:16]], SBOX[x[15:8]], SBOX[x[7:0]]};
  endfunction

  task automatic expand_key(input logic [255:0] key, input int nk, input int nr);
    logic [31:0] t;
    logic [7:0]  rcon;
    rcon = 8'h01;
    for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
    for (int i = nk; i < 4 * (nr + 1); i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t    = sub_word({t[23:0], t[31:24]}) ^ {rcon, 24'h0};
        rcon = {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);
      end else if (nk > 6 && i % nk == 4) begin
        t = sub_word(t);
      end
      w[i] = t ^ w[i-nk];
    end
  endtask

  task automatic load14(input logic [255:0] key);
    expand_key(key, 8, 14);
    for (int r = 0; r < 16; r++) ks14[r] = (r <= 14) ? {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]} : '0;
  endtask

  task automatic load10(input logic [255:0] key);
    expand_key(key, 4, 10);
    for (int r = 0; r < 16; r++) ks10[r] = (r <= 10) ? {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]} : '0;
  endtask

  // ---------------- drivers (called at posedge + 1) ----------------
  task automatic send14(input logic [127:0] d, input logic [127:0] e, output int acc);
    int n;
    n = 0;
    acc = -1;
    in_valid14 = 1'b1;
    in_data14  = d;
    #1;
    while (!in_ready14 && n < 100) begin @(posedge clk); #1; n++; end
    if (!in_ready14) begin
      chk("accept14_timeout", 128'(in_ready14), 128'(1));
      in_valid14 = 1'b0;
      return;
    end
    @(posedge clk); #1;
    acc        = cyc;
    in_valid14 = 1'b0;
    in_data14  = '0;
    exp_q14.push_back(e);
  endtask

  task automatic send10(input logic [127:0] d, input logic [127:0] e, output int acc);
    int n;
    n = 0;
    acc = -1;
    in_valid10 = 1'b1;
    in_data10  = d;
    #1;
    while (!in_ready10 && n < 100) begin @(posedge clk); #1; n++; end
    if (!in_ready10) begin
      chk("accept10_timeout", 128'(in_ready10), 128'(1));
      in_valid10 = 1'b0;
      return;
    end
    @(posedge clk); #1;
    acc        = cyc;
    in_valid10 = 1'b0;
    in_data10  = '0;
    exp_q10.push_back(e);
  endtask

  task automatic wait_out14(output int t);
    int n;
    n = 0;
    while (!out_valid14 && n < 100) begin @(posedge clk); #1; n++; end
    chk("out_valid14_timeout", 128'(out_valid14), 128'(1));
    t = cyc;
  endtask

  task automatic wait_out10(output int t);
    int n;
    n = 0;
    while (!out_valid10 && n < 100) begin @(posedge clk); #1; n++; end
    chk("out_valid10_timeout", 128'(out_valid10), 128'(1));
    t = cyc;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int acc, t, h;
    rst_n = 1'b0;
    in_valid14 = 1'b0; in_data14 = '0; key_valid14 = 1'b1; out_ready14 = 1'b1;
    in_valid10 = 1'b0; in_data10 = '0; key_valid10 = 1'b1; out_ready10 = 1'b1;
    load14(KEY256);
    load10(KEY128A);
    #12;
    chk("rst_in_ready14", 128'(in_ready14), 128'(0));
    chk("rst_out_valid14", 128'(out_valid14), 128'(0));
    chk("rst_out_data14", out_data14, 128'(0));
    chk("rst_key_idx14", 128'(key_idx14), 128'(0));
    chk("rst_in_ready10", 128'(in_ready10), 128'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    chk("idle_in_ready14", 128'(in_ready14), 128'(1));

    // AES-256 known answer, ARK/round-1 probes and key index order
    send14(PT, CT14, acc);
    chk("ark_state", d14.state_reg, 128'h00102030405060708090a0b0c0d0e0f0);
    for (int k = 1; k <= 14; k++) begin
      chk("key_idx_seq", 128'(key_idx14), 128'(k));
      if (k == 2) chk("round1_state", d14.state_reg, 128'h4f63760643e0aa85efa7213201a4e705);
      @(posedge clk); #1;
    end
    chk("latency14", 128'(out_valid14), 128'(1));
    chk("latency14_cycles", 128'(cyc - acc), 128'(14));
    @(posedge clk); #1;
    chk("after_hs_key_idx", 128'(key_idx14), 128'(0));
    chk("after_hs_in_ready", 128'(in_ready14), 128'(1));

    // no accept without a key schedule, then a 3-cycle key stall at rnd=5
    key_valid14 = 1'b0; in_valid14 = 1'b1; in_data14 = PT;
    repeat (3) begin
      @(posedge clk); #1;
      chk("nokey_in_ready", 128'(in_ready14), 128'(0));
      chk("nokey_idle", 128'(d14.state), 128'(IDLE));
    end
    in_valid14 = 1'b0; key_valid14 = 1'b1;
    send14(PT, CT14, acc);
    repeat (4) begin @(posedge clk); #1; end
    chk("stall_start_idx", 128'(key_idx14), 128'(5));
    key_valid14 = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      chk("stall_key_idx", 128'(key_idx14), 128'(5));
    end
    key_valid14 = 1'b1;
    wait_out14(t);
    chk("stall_latency", 128'(t - acc), 128'(17));
    @(posedge clk); #1;

    // consumer backpressure; second block waits for the handshake
    out_ready14 = 1'b0;
    send14(PT, CT14, acc);
    wait_out14(t);
    chk("bp_latency", 128'(t - acc), 128'(14));
    in_valid14 = 1'b1; in_data14 = PT;
    repeat (10) begin
      @(posedge clk); #1;
      chk("bp_out_data", out_data14, CT14);
      chk("bp_out_valid", 128'(out_valid14), 128'(1));
      chk("bp_in_ready", 128'(in_ready14), 128'(0));
    end
    out_ready14 = 1'b1;
    h = cyc;
    send14(PT, CT14, acc);
    chk("accept_after_hs", 128'(acc), 128'(h + 2));
    wait_out14(t);
    send14(PT, CT14, acc);
    wait_out14(t);
    chk("b2b_latency", 128'(t - acc), 128'(14));
    @(posedge clk); #1;

    // reset in the middle of a block
    send14(PT, CT14, acc);
    repeat (6) begin @(posedge clk); #1; end
    chk("pre_rst_idx", 128'(key_idx14), 128'(7));
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 128'(out_valid14), 128'(0));
    chk("midrst_state", 128'(d14.state), 128'(IDLE));
    chk("midrst_key_idx", 128'(key_idx14), 128'(0));
    chk("midrst_in_ready", 128'(in_ready14), 128'(0));
    chk("midrst_out_data", out_data14, 128'(0));
    if (exp_q14.size() > 0) void'(exp_q14.pop_back());
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    send14(PT, CT14, acc);
    wait_out14(t);
    chk("post_rst_latency", 128'(t - acc), 128'(14));
    @(posedge clk); #1;

    // AES-128 instance: two known-answer vectors
    send10(PT, CT10, acc);
    wait_out10(t);
    chk("latency10", 128'(t - acc), 128'(10));
    @(posedge clk); #1;
    load10(KEY128B);
    send10(PTB, CTB, acc);
    wait_out10(t);
    chk("latency10_b", 128'(t - acc), 128'(10));

    repeat (3) begin @(posedge clk); #1; end
    chk("q14_drained", 128'(exp_q14.size()), 128'(0));
    chk("q10_drained", 128'(exp_q10.size()), 128'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got %0d cycles expected fewer", cyc);
    $fatal(1, "watchdog");
  end
endmodule
